mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 32 +++
 rtl/mem_byte_array.sv | 54 +++++
 rtl/mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared types and constants for the memory responder:
//   mem_resp_state_t : responder FSM states (idle, latency wait, response)
//   mr_op_t          : latched operation kind
//   MR_MAX_LATENCY   : largest supported request-to-response latency
//   mr_cnt_width()   : bits needed for a counter spanning 0..max_val
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int MR_MAX_LATENCY = 15;

    function automatic int mr_cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    localparam int MR_CNT_W = mr_cnt_width(MR_MAX_LATENCY);

    typedef logic [MR_CNT_W-1:0] mr_cnt_t;

    typedef enum logic [1:0] {
        MR_IDLE,
        MR_WAIT,
        MR_RESP
    } mem_resp_state_t;

    typedef enum logic {
        MR_OP_READ,
        MR_OP_WRITE
    } mr_op_t;

endpackage

// File: rtl/mem_byte_array.sv
// -----------------------------------------------------------------------------
// mem_byte_array
// 2**ADDR_W x 32-bit storage with byte-lane writes and one synchronous,
// registered read port. The read register holds its value until the next
// enabled read and is the only part of this block that is reset.
// Ports:
//   clk, rst_n          : clock, async active-low reset (read register only)
//   rd_en_i, rd_addr_i  : load rd_data_o from rd_addr_i on the next edge
//   rd_data_o           : registered read data
//   wr_en_i, wr_addr_i  : write strobe and word address
//   wr_be_i, wr_data_i  : byte-lane enables (bit i -> data[8i+7:8i]) and data
// -----------------------------------------------------------------------------
module mem_byte_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [3:0]        wr_be_i,
    input  logic [31:0]       wr_data_i
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rd_data_q;

    // NOTE: the storage array has no reset; clearing thousands of words would
    // cost a reset fan-out to every bit cell and nothing relies on it.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_i[i]) begin
                    mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
                end
            end
        end
    end

    // NOTE: state is always updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the single-port mem_read/mem_write handshake.
// A request seen in IDLE is latched (word address, data, byte enables, op);
// mem_resp is high during the RESP state, which is entered LATENCY-1 edges
// after the accepting edge, so the initiator samples it on edge N+LATENCY.
// Reads load mem_rdata on the edge entering RESP; writes update the array on
// the edge leaving RESP. A read+write request is handled as a write.
//
// Parameters: ADDR_W (word-address bits), LATENCY (1..MR_MAX_LATENCY)
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   mem_read, mem_write            : request strobes, held until mem_resp
//   mem_byte_enable, mem_address,
//   mem_wdata                      : write lanes, byte address, write data
//   mem_resp                       : one-cycle completion pulse
//   mem_rdata                      : read data, held until next read response
//   proto_err                      : sticky protocol-violation flag
//
// Build option: define MEM_RESPONDER_PROTO_CHECK_EN to enable the protocol
// checker driving proto_err; otherwise proto_err is tied low.
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        proto_err
);

    mem_resp_state_t   state_q, state_d;
    mr_cnt_t           cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    mr_op_t            op_q, op_d;

    logic              req;
    mr_op_t            req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              rd_en;
    logic              wr_en;

    // Byte-offset bits and bits above the array size take no part in
    // addressing; addresses alias modulo the array size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[31:ADDR_W+2], mem_address[1:0]};

    assign req      = mem_read | mem_write;
    assign req_op   = mem_write ? MR_OP_WRITE : MR_OP_READ;
    assign req_addr = mem_address[ADDR_W+1:2];

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        op_d    = op_q;
        unique case (state_q)
            MR_IDLE: begin
                if (req) begin
                    addr_d  = req_addr;
                    wdata_d = mem_wdata;
                    be_d    = mem_byte_enable;
                    op_d    = req_op;
                    cnt_d   = mr_cnt_t'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? MR_RESP : MR_WAIT;
                end
            end
            MR_WAIT: begin
                cnt_d = cnt_q - mr_cnt_t'(1);
                if (cnt_q == mr_cnt_t'(1)) begin
                    state_d = MR_RESP;
                end
            end
            MR_RESP: begin
                state_d = MR_IDLE;
            end
            default: begin
                state_d = MR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MR_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            op_q    <= MR_OP_READ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            op_q    <= op_d;
        end
    end

    // RESP is only ever entered from IDLE or WAIT, so this fires once per
    // transaction; addr_d already carries the incoming address when LATENCY=1.
    assign rd_en = (state_d == MR_RESP) && (state_q != MR_RESP) && (op_d == MR_OP_READ);
    assign wr_en = (state_q == MR_RESP) && (op_q == MR_OP_WRITE);

    mem_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en_i   (rd_en),
        .rd_addr_i (addr_d),
        .rd_data_o (mem_rdata),
        .wr_en_i   (wr_en),
        .wr_addr_i (addr_q),
        .wr_be_i   (be_q),
        .wr_data_i (wdata_q)
    );

    assign mem_resp = (state_q == MR_RESP);

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
    logic [31:0] chk_addr_q;
    logic        proto_err_q;
    logic        viol;
    logic        busy;

    assign busy = (state_q != MR_IDLE);

    // The full byte address is kept here because any change is a violation,
    // even in bits the array ignores.
    always_comb begin
        viol = mem_read & mem_write;
        if (busy) begin
            viol = viol
                 | !req
                 | (mem_address     != chk_addr_q)
                 | (mem_wdata       != wdata_q)
                 | (mem_byte_enable != be_q)
                 | (req_op          != op_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_addr_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (!busy && req) begin
                chk_addr_q <= mem_address;
            end
            proto_err_q <= proto_err_q | viol;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && viol) begin
            $error("mem_responder: protocol violation in state %s", state_q.name());
        end
    end
`endif

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int A_W   = 10;
    localparam int LAT_A = 2;

    logic        clk;
    logic        rst_n;

    logic        a_read, a_write;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata;
    logic        a_resp, a_perr;
    logic [31:0] a_rdata;

    logic        b_read, b_write;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata;
    logic        b_resp, b_perr;
    logic [31:0] b_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference memory: word index -> contents, built only from the
    // transactions the bench itself issued.
    logic [31:0] model_a [int];
    logic [31:0] model_b [int];

    mem_responder #(.ADDR_W(A_W), .LATENCY(LAT_A)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (a_read),
        .mem_write       (a_write),
        .mem_byte_enable (a_be),
        .mem_address     (a_addr),
        .mem_wdata       (a_wdata),
        .mem_resp        (a_resp),
        .mem_rdata       (a_rdata),
        .proto_err       (a_perr)
    );

    mem_responder #(.ADDR_W(A_W), .LATENCY(1)) dut_l1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (b_read),
        .mem_write       (b_write),
        .mem_byte_enable (b_be),
        .mem_address     (b_addr),
        .mem_wdata       (b_wdata),
        .mem_resp        (b_resp),
        .mem_rdata       (b_rdata),
        .proto_err       (b_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % (1 << A_W));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    task automatic model_write_a(input logic [31:0] addr, input logic [31:0] d,
                                 input logic [3:0] be);
        int k;
        k = word_of(addr);
        if (!model_a.exists(k)) model_a[k] = 32'h0;
        model_a[k] = merge(model_a[k], d, be);
    endtask

    // Drive one request on the LATENCY=2 instance, hold it until mem_resp
    // has been seen, then drop it. lat = number of edges from the accepting
    // edge to the edge where mem_resp is sampled high (0 on timeout);
    // one_shot = mem_resp was low again one cycle later.
    task automatic txn_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] d, input logic [3:0] be,
                         output int lat, output logic [31:0] rdata,
                         output logic one_shot);
        lat = 0;
        rdata = '0;
        one_shot = 1'b0;
        @(negedge clk);
        a_read = rd; a_write = wr; a_addr = addr; a_wdata = d; a_be = be;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (a_resp === 1'b1) begin
                lat = k;
                rdata = a_rdata;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            one_shot = (a_resp === 1'b0);
        end
        a_read = 1'b0; a_write = 1'b0;
    endtask

    task automatic txn_b_write(input logic [31:0] addr, input logic [31:0] d,
                               output int lat);
        lat = 0;
        @(negedge clk);
        b_write = 1'b1; b_addr = addr; b_wdata = d; b_be = 4'hF;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (b_resp === 1'b1) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
        b_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_read = 0; a_write = 0; a_be = 0; a_addr = 0; a_wdata = 0;
        b_read = 0; b_write = 0; b_be = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0", a_resp); end
        n_checks++;
        if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
        n_checks++;
        if (a_perr !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b want 0", a_perr); end
        n_checks++;
        if (b_resp !== 1'b0 || b_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_l1: resp %b rdata %h want 0/0", b_resp, b_rdata);
        end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd; logic one;
        txn_a(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, lat, rd, one);
        model_write_a(32'h40, 32'hDEADBEEF, 4'hF);
        n_checks++;
        if (lat !== LAT_A || !one) begin
            n_fail++; $display("FAIL basic_write_latency: got %0d one_shot %b want %0d/1", lat, one, LAT_A);
        end
        txn_a(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, one);
        n_checks++;
        if (lat !== LAT_A || !one) begin
            n_fail++; $display("FAIL basic_read_latency: got %0d one_shot %b want %0d/1", lat, one, LAT_A);
        end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_read_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic one;
        txn_a(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, lat, rd, one);
        model_write_a(32'h40, 32'h11223344, 4'hF);
        txn_a(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, lat, rd, one);
        model_write_a(32'h40, 32'hAABBCCDD, 4'b0101);
        txn_a(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, one);
        n_checks++;
        if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_lanes: got %h want 11bb33dd", rd); end
        // Zero byte enables: handshake completes, contents unchanged.
        txn_a(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, lat, rd, one);
        n_checks++;
        if (lat !== LAT_A) begin n_fail++; $display("FAIL be_zero_latency: got %0d want %0d", lat, LAT_A); end
        txn_a(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, one);
        n_checks++;
        if (rd !== model_a[word_of(32'h40)]) begin
            n_fail++; $display("FAIL be_zero_data: got %h want %h", rd, model_a[word_of(32'h40)]);
        end
    endtask

    task automatic test_alias();
        int lat; logic [31:0] rd; logic one;
        txn_a(1'b0, 1'b1, 32'h1003, 32'h5A5A5A5A, 4'hF, lat, rd, one);
        model_write_a(32'h1003, 32'h5A5A5A5A, 4'hF);
        txn_a(1'b1, 1'b0, 32'h0000, 32'h0, 4'h0, lat, rd, one);
        n_checks++;
        if (rd !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL alias: got %h want 5a5a5a5a", rd); end
    endtask

    task automatic test_early_drop();
        int lat; logic [31:0] exp;
        exp = model_a[word_of(32'h40)];
        @(negedge clk);
        a_read = 1'b1; a_addr = 32'h40;
        @(negedge clk);
        a_read = 1'b0; a_addr = 32'h0;
        lat = (a_resp === 1'b1) ? 1 : 0;
        for (int k = 2; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (a_resp === 1'b1) lat = k;
        end
        n_checks++;
        if (lat !== LAT_A || a_rdata !== exp) begin
            n_fail++; $display("FAIL early_drop: lat %0d rdata %h want %0d/%h", lat, a_rdata, LAT_A, exp);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (a_resp !== 1'b0) begin n_fail++; $display("FAIL early_drop_extra_resp: got %b want 0", a_resp); end
    endtask

    task automatic test_latched_inputs();
        int lat; logic [31:0] rd; logic one;
        @(negedge clk);
        a_write = 1'b1; a_addr = 32'h200; a_wdata = 32'h0BADF00D; a_be = 4'hF;
        @(negedge clk);
        a_addr = 32'h0; a_wdata = 32'hFFFFFFFF; a_be = 4'b0001;
        repeat (2) @(negedge clk);
        a_write = 1'b0;
        model_write_a(32'h200, 32'h0BADF00D, 4'hF);
        txn_a(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, lat, rd, one);
        n_checks++;
        if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL latched_data: got %h want 0badf00d", rd); end
        txn_a(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, one);
        n_checks++;
        if (rd !== model_a[0]) begin n_fail++; $display("FAIL latched_other_word: got %h want %h", rd, model_a[0]); end
    endtask

    task automatic test_simultaneous();
        int lat; logic [31:0] rd; logic [31:0] prev; logic one; logic want_perr;
        prev = model_a[0];
        txn_a(1'b1, 1'b1, 32'h100, 32'h600DCAFE, 4'hF, lat, rd, one);
        model_write_a(32'h100, 32'h600DCAFE, 4'hF);
        n_checks++;
        if (rd !== prev) begin n_fail++; $display("FAIL rw_is_write_rdata: got %h want %h", rd, prev); end
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        want_perr = 1'b1;
`else
        want_perr = 1'b0;
`endif
        n_checks++;
        if (a_perr !== want_perr) begin n_fail++; $display("FAIL proto_err: got %b want %b", a_perr, want_perr); end
        txn_a(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, lat, rd, one);
        n_checks++;
        if (rd !== 32'h600DCAFE) begin n_fail++; $display("FAIL rw_write_done: got %h want 600dcafe", rd); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] addrs [6];
        for (int i = 0; i < 6; i++) begin
            addrs[i] = 32'h300 + 32'(i * 4);
            model_b[word_of(addrs[i])] = $urandom;
            txn_b_write(addrs[i], model_b[word_of(addrs[i])], lat);
            n_checks++;
            if (lat !== 1) begin n_fail++; $display("FAIL l1_write_latency[%0d]: got %0d want 1", i, lat); end
        end
        @(negedge clk);
        b_read = 1'b1; b_addr = addrs[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (b_resp !== 1'b1 || b_rdata !== model_b[word_of(addrs[i])]) begin
                n_fail++;
                $display("FAIL b2b_resp[%0d]: resp %b rdata %h want 1/%h", i, b_resp, b_rdata,
                         model_b[word_of(addrs[i])]);
            end
            @(negedge clk);
            n_checks++;
            if (b_resp !== 1'b0) begin n_fail++; $display("FAIL b2b_gap[%0d]: resp %b want 0", i, b_resp); end
            if (i < 5) b_addr = addrs[i + 1];
            else b_read = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int lat; int seen; logic [31:0] rd; logic one;
        txn_a(1'b0, 1'b1, 32'h80, 32'h12345678, 4'hF, lat, rd, one);
        model_write_a(32'h80, 32'h12345678, 4'hF);
        @(negedge clk);
        a_write = 1'b1; a_addr = 32'h80; a_wdata = 32'hCAFEF00D; a_be = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        a_write = 1'b0;
        seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_resp === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL reset_mid_resp: got %0d pulses want 0", seen); end
        n_checks++;
        if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mid_rdata: got %h want 0", a_rdata); end
        txn_a(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, lat, rd, one);
        n_checks++;
        if (rd !== 32'h12345678) begin n_fail++; $display("FAIL reset_mid_discard: got %h want 12345678", rd); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic one;
        logic [31:0] last_rd; logic [31:0] addr; logic [31:0] d; logic [3:0] be;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            txn_a(1'b0, 1'b1, 32'h800 + 32'(i * 4), d, 4'hF, lat, rd, one);
            model_write_a(32'h800 + 32'(i * 4), d, 4'hF);
        end
        txn_a(1'b1, 1'b0, 32'h800, 32'h0, 4'h0, lat, rd, one);
        last_rd = model_a[word_of(32'h800)];
        n_checks++;
        if (rd !== last_rd) begin n_fail++; $display("FAIL rand_first_read: got %h want %h", rd, last_rd); end
        for (int i = 0; i < 40; i++) begin
            // Random upper and byte-offset bits exercise aliasing and alignment.
            addr = ($urandom & 32'hFFFF_F003) | 32'h800 | (32'($urandom_range(0, 15)) << 2);
            d = $urandom;
            be = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                txn_a(1'b0, 1'b1, addr, d, be, lat, rd, one);
                model_write_a(addr, d, be);
            end else begin
                txn_a(1'b1, 1'b0, addr, d, be, lat, rd, one);
                last_rd = model_a[word_of(addr)];
            end
            n_checks++;
            if (lat !== LAT_A || !one || rd !== last_rd) begin
                n_fail++;
                $display("FAIL rand[%0d] addr %h: lat %0d one_shot %b rdata %h want %0d/1/%h",
                         i, addr, lat, one, rd, LAT_A, last_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_alias();
        test_early_drop();
        test_latched_inputs();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
